seq_divider: RTL



---
 rtl/seq_divider.sv | 135 +++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative restoring divider, one quotient bit per clock, signed or unsigned
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] dvd_sh;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] prem;
    logic             q_neg;
    logic             r_neg;

    logic             accept;
    logic             divisor_zero;
    logic             last_step;
    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0] dvs_abs;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic             q_bit;
    logic [WIDTH-1:0] prem_next;
    logic [WIDTH-1:0] quo_next;

    always_comb begin
        accept       = start && (state != RUN);
        divisor_zero = (divisor == '0);
        last_step    = (count == CW'(1));
        dvd_neg      = signed_op & dividend[WIDTH-1];
        dvs_neg      = signed_op & divisor[WIDTH-1];
        dvd_abs      = dvd_neg ? -dividend : dividend;
        dvs_abs      = dvs_neg ? -divisor : divisor;
        // The shifted partial remainder keeps its top bit so large unsigned divisors stay exact.
        shifted      = {prem, dvd_sh[WIDTH-1]};
        trial        = {1'b0, shifted} - {2'b00, dvs_mag};
        q_bit        = ~trial[WIDTH+1];
        prem_next    = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_next     = {dvd_sh[WIDTH-2:0], q_bit};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = divisor_zero ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_next = divisor_zero ? DONE : RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            dvd_sh      <= '0;
            dvs_mag     <= '0;
            prem        <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            count       <= CW'(WIDTH);
            dvd_sh      <= dvd_abs;
            dvs_mag     <= dvs_abs;
            prem        <= '0;
            q_neg       <= dvd_neg ^ dvs_neg;
            r_neg       <= dvd_neg;
            div_by_zero <= divisor_zero;
            if (divisor_zero) begin
                quotient  <= '1;
                remainder <= dividend;
            end
        end else if (state == RUN) begin
            count  <= count - CW'(1);
            dvd_sh <= quo_next;
            prem   <= prem_next;
            if (last_step) begin
                quotient  <= q_neg ? -quo_next : quo_next;
                remainder <= r_neg ? -prem_next : prem_next;
            end
        end
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

endmodule
